// File: rtl/pipe_skid_stage.sv
// pipe_skid_stage
//   Ready/valid pipeline register that replaces fixed inter-stage registers
//   and per-stage enable wiring. The payload is opaque and passed bit-exact.
//   SKID=1 keeps two entries so in_ready can come from a flop while
//   sustaining one payload per cycle. SKID=0 keeps one entry, and its
//   in_ready is combinational.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   flush      synchronous clear of all entries; has the highest priority
//   in_valid   upstream payload valid
//   in_ready   stage can accept (in_fire = in_valid & in_ready)
//   in_data    upstream payload
//   out_valid  out_data holds a valid payload
//   out_ready  downstream accepts (out_fire = out_valid & out_ready)
//   out_data   payload to the next stage
//   occupancy  entries held: 0..2, or 0..1 when SKID=0
module pipe_skid_stage #(
    parameter int unsigned            DATA_WIDTH  = 32,
    parameter int unsigned            SKID        = 1,
    parameter logic [DATA_WIDTH-1:0]  RESET_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [1:0]            occupancy
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    logic in_fire;
    logic out_fire;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    generate
        if (SKID != 0) begin : g_skid
            state_t                state_q, state_d;
            logic [DATA_WIDTH-1:0] main_q, skid_q;
            logic                  ready_q;
            logic                  load_main, load_skid, main_from_skid;

            always_comb begin
                state_d        = state_q;
                load_main      = 1'b0;
                load_skid      = 1'b0;
                main_from_skid = 1'b0;
                case (state_q)
                    EMPTY: begin
                        if (in_fire) begin
                            state_d   = BUSY;
                            load_main = 1'b1;
                        end
                    end
                    BUSY: begin
                        if (in_fire && out_fire) begin
                            load_main = 1'b1;
                        end else if (in_fire) begin
                            state_d   = FULL;
                            load_skid = 1'b1;
                        end else if (out_fire) begin
                            state_d = EMPTY;
                        end
                    end
                    FULL: begin
                        // The skid entry drains into the output register.
                        // in_ready is low here, so there is no new payload to place.
                        if (out_fire) begin
                            state_d        = BUSY;
                            load_main      = 1'b1;
                            main_from_skid = 1'b1;
                        end
                    end
                    default: state_d = EMPTY;
                endcase
                // A flush drops everything, including a same-cycle in_fire.
                // The data registers keep their contents; they are don't-care while invalid.
                if (flush) begin
                    state_d   = EMPTY;
                    load_main = 1'b0;
                    load_skid = 1'b0;
                end
            end

            // in_ready is registered from the next state, so the upstream
            // stage never sees a combinational path through this stage.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    state_q <= EMPTY;
                    ready_q <= 1'b1;
                end else begin
                    state_q <= state_d;
                    ready_q <= (state_d != FULL);
                end
            end

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    main_q <= RESET_VALUE;
                    skid_q <= RESET_VALUE;
                end else begin
                    if (load_main) main_q <= main_from_skid ? skid_q : in_data;
                    if (load_skid) skid_q <= in_data;
                end
            end

            assign in_ready  = ready_q;
            assign out_valid = (state_q != EMPTY);
            assign out_data  = main_q;
            assign occupancy = (state_q == FULL) ? 2'd2 :
                               (state_q == BUSY) ? 2'd1 : 2'd0;
        end else begin : g_single
            logic                  valid_q;
            logic [DATA_WIDTH-1:0] main_q;

            // The single entry can be replaced on the same edge it is consumed.
            assign in_ready = ~valid_q | out_ready;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    valid_q <= 1'b0;
                end else if (flush) begin
                    valid_q <= 1'b0;
                end else if (in_fire) begin
                    valid_q <= 1'b1;
                end else if (out_fire) begin
                    valid_q <= 1'b0;
                end
            end

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    main_q <= RESET_VALUE;
                end else if (in_fire && !flush) begin
                    main_q <= in_data;
                end
            end

            assign out_valid = valid_q;
            assign out_data  = main_q;
            assign occupancy = {1'b0, valid_q};
        end
    endgenerate

endmodule
